// File: rtl/sargantana_icache_flush_ctrl.sv
// -----------------------------------------------------------------------------
// sargantana_icache_flush_ctrl
//
// Full instruction-cache invalidation sequencer for fence.i.
//
// A flush request first blocks new lookups and waits until the icache
// controller has drained (controller idle, no L2 refill outstanding). Only
// then is the shared valid-array write port taken over. The sweep clears every
// way-valid bit, one set per cycle, in ascending set order. A one-cycle
// acknowledge closes the sequence.
//
// Requests that arrive while the controller is draining are absorbed into the
// flush already in progress. Requests that arrive during the sweep or the
// acknowledge cycle may have been issued after some sets were already cleared.
// Such requests are remembered in a single pending bit, and one further
// complete flush is run for them.
//
// All outputs are registered. They are computed from the next state, so that
// they line up with the registered state. An asynchronous reset forces all
// outputs to zero at once.
//
// Optional build macro:
//   ICACHE_FLUSH_PERF_EN - adds flush_stall_cnt_o. This is a saturating 32-bit
//                          count of cycles in which lookups were blocked.
// -----------------------------------------------------------------------------
module sargantana_icache_flush_ctrl #(
    parameter  int ICACHE_DEPTH = 64,
    parameter  int ICACHE_N_WAY = 4,
    localparam int IDX_W        = $clog2(ICACHE_DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    flush_req_i,
    input  logic                    ictrl_idle_i,
    input  logic                    refill_pending_i,
    output logic                    block_req_o,
    output logic                    vld_we_o,
    output logic [IDX_W-1:0]        vld_addr_o,
    output logic [ICACHE_N_WAY-1:0] vld_wdata_o,
    output logic                    flush_busy_o,
    output logic                    flush_ack_o
`ifdef ICACHE_FLUSH_PERF_EN
    ,
    output logic [31:0]             flush_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(ICACHE_DEPTH - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;

    // Registered output copies. Busy and block are the same signal.
    logic             busy_q, busy_d;
    logic             we_q, we_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic             ack_q, ack_d;

    // Next-state logic, including next values for the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;

        unique case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A request seen here is merged into this flush. The sweep
                // has not started yet, so that request is fully covered.
                if (ictrl_idle_i && !refill_pending_i) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                // The set index is a power of two. It wraps to zero after the
                // final set, which leaves it ready for any later sweep.
                cnt_d = cnt_q + IDX_W'(1);
                if (flush_req_i) begin
                    pend_d = 1'b1;
                end
                if (cnt_q == LAST_SET) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A request in the acknowledge cycle counts as pending,
                // just like one seen during the sweep.
                if (pend_q || flush_req_i) begin
                    state_d = DRAIN;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        we_d   = (state_d == SWEEP);
        addr_d = we_d ? cnt_d : '0;
        ack_d  = (state_d == DONE);
    end

    // Flush FSM: state, set counter, pending bit and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
        end
    end

    assign flush_busy_o = busy_q;
    assign block_req_o  = busy_q;
    assign vld_we_o     = we_q;
    assign vld_addr_o   = addr_q;
    assign flush_ack_o  = ack_q;
    // An invalidation only ever clears valid bits.
    assign vld_wdata_o  = '0;

`ifdef ICACHE_FLUSH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles in which lookups are blocked, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (busy_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register; only reset clears it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign flush_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sargantana_icache_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sargantana_icache_flush_ctrl
//
// Table-driven flush scenarios. When a flush is launched, the expected sweep
// addresses are queued. A negedge monitor pops them as the DUT writes. The
// monitor also counts acks and records when the sweep writes and the ack
// occur. Separate sequences cover reset state and a reset during the sweep.
// When ICACHE_FLUSH_PERF_EN is defined, the stall counter is checked as well.
// -----------------------------------------------------------------------------
module tb_sargantana_icache_flush_ctrl;

    localparam int DEPTH = 64;
    localparam int NWAY  = 4;
    localparam int IW    = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            rstn_i = 1'b0;
    logic            flush_req_i = 1'b0;
    logic            ictrl_idle_i = 1'b1;
    logic            refill_pending_i = 1'b0;
    logic            block_req_o;
    logic            vld_we_o;
    logic [IW-1:0]   vld_addr_o;
    logic [NWAY-1:0] vld_wdata_o;
    logic            flush_busy_o;
    logic            flush_ack_o;
`ifdef ICACHE_FLUSH_PERF_EN
    logic [31:0]     flush_stall_cnt_o;
`endif

    sargantana_icache_flush_ctrl #(
        .ICACHE_DEPTH(DEPTH),
        .ICACHE_N_WAY(NWAY)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn_i),
        .flush_req_i      (flush_req_i),
        .ictrl_idle_i     (ictrl_idle_i),
        .refill_pending_i (refill_pending_i),
        .block_req_o      (block_req_o),
        .vld_we_o         (vld_we_o),
        .vld_addr_o       (vld_addr_o),
        .vld_wdata_o      (vld_wdata_o),
        .flush_busy_o     (flush_busy_o),
        .flush_ack_o      (flush_ack_o)
`ifdef ICACHE_FLUSH_PERF_EN
        ,
        .flush_stall_cnt_o(flush_stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state shared between the driver and the monitor.
    int exp_q[$];
    int acks = 0;
    int wr_since_ack = 0;
    int first_we = -1;
    int last_we = -1;
    int ack_cyc = -1;
    bit prev_ack = 1'b0;
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        int e;
        if (mon_en && rstn_i) begin
            chk("block_eq_busy", block_req_o, flush_busy_o);
            if (vld_we_o) begin
                chk("wdata_zero", vld_wdata_o, 0);
                chk("block_during_write", block_req_o, 1);
                chk("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sweep_addr", vld_addr_o, e);
                end
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
                wr_since_ack++;
            end else begin
                chk("addr_zero_outside_sweep", vld_addr_o, 0);
            end
            if (flush_ack_o) begin
                acks++;
                ack_cyc = cyc;
                chk("writes_per_ack", wr_since_ack, DEPTH);
                wr_since_ack = 0;
                chk("ack_block", block_req_o, 1);
                chk("ack_single_cycle", prev_ack, 0);
            end
            prev_ack = flush_ack_o;
        end
    end

    typedef struct {
        int hold;         // DRAIN cycles with the drain condition held false
        bit hold_refill;  // hold by refill_pending (1) or by ictrl_idle=0 (0)
        int pulse_drain;  // hold-loop index of an extra request (-1: none)
        int pulse_addr;   // sweep address at which to raise an extra request (-1: none)
        int exp_acks;
    } vec_t;

    task automatic run_vec(input int id, input vec_t v);
        int  c0, rel_cyc, n, end_cyc;
        bit  pulsed;
        exp_q.delete();
        for (int k = 0; k < v.exp_acks * DEPTH; k++) exp_q.push_back(k % DEPTH);
        acks = 0; wr_since_ack = 0; first_we = -1; last_we = -1; ack_cyc = -1;

        @(posedge clk); #1;
        if (v.hold > 0) begin
            ictrl_idle_i     = v.hold_refill ? 1'b1 : 1'b0;
            refill_pending_i = v.hold_refill ? 1'b1 : 1'b0;
        end else begin
            ictrl_idle_i = 1'b1; refill_pending_i = 1'b0;
        end
        flush_req_i = 1'b1;
        c0 = cyc;
        @(posedge clk); #1 flush_req_i = 1'b0;

        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk); #2;
            chk("drain_block", block_req_o, 1);
            chk("drain_no_write", vld_we_o, 0);
            if (i == v.pulse_drain) begin
                flush_req_i = 1'b1;
                @(posedge clk); #1 flush_req_i = 1'b0;
            end
        end
        if (v.hold > 0) begin
            @(posedge clk); #1;
            ictrl_idle_i = 1'b1; refill_pending_i = 1'b0;
            rel_cyc = cyc;
        end else begin
            rel_cyc = c0 + 1;
        end

        pulsed = 1'b0; n = 0; end_cyc = -1;
        while (n < 400) begin
            @(negedge clk); #2;
            n++;
            if (v.pulse_addr >= 0 && !pulsed && vld_we_o && (int'(vld_addr_o) == v.pulse_addr)) begin
                pulsed = 1'b1;
                flush_req_i = 1'b1;
                @(posedge clk); #1 flush_req_i = 1'b0;
            end else if (acks == v.exp_acks && !flush_busy_o) begin
                end_cyc = cyc;
                break;
            end
        end
        chk($sformatf("v%0d_finished_in_budget", id), end_cyc >= 0, 1);
        chk($sformatf("v%0d_ack_count", id), acks, v.exp_acks);
        chk($sformatf("v%0d_queue_empty", id), exp_q.size(), 0);
        chk($sformatf("v%0d_first_write_cycle", id), first_we, rel_cyc + 1);
        if (v.exp_acks == 1) begin
            chk($sformatf("v%0d_last_write_cycle", id), last_we, rel_cyc + DEPTH);
            chk($sformatf("v%0d_ack_cycle", id), ack_cyc, rel_cyc + DEPTH + 1);
            chk($sformatf("v%0d_idle_cycle", id), end_cyc, rel_cyc + DEPTH + 2);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        bit hit;
        vecs[0] = '{hold: 0,  hold_refill: 1'b0, pulse_drain: -1, pulse_addr: -1, exp_acks: 1};
        vecs[1] = '{hold: 10, hold_refill: 1'b0, pulse_drain: -1, pulse_addr: -1, exp_acks: 1};
        vecs[2] = '{hold: 5,  hold_refill: 1'b1, pulse_drain: -1, pulse_addr: -1, exp_acks: 1};
        vecs[3] = '{hold: 4,  hold_refill: 1'b0, pulse_drain: 1,  pulse_addr: -1, exp_acks: 1};
        vecs[4] = '{hold: 0,  hold_refill: 1'b0, pulse_drain: -1, pulse_addr: 30, exp_acks: 2};

        // Reset state
        rstn_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_block", block_req_o, 0);
        chk("rst_we", vld_we_o, 0);
        chk("rst_addr", vld_addr_o, 0);
        chk("rst_busy", flush_busy_o, 0);
        chk("rst_ack", flush_ack_o, 0);
        chk("rst_wdata", vld_wdata_o, 0);
        #3 rstn_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", flush_busy_o, 0);
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
`ifdef ICACHE_FLUSH_PERF_EN
            if (i == 0) chk("perf_stall_cnt", flush_stall_cnt_o, 66);
`endif
        end

        // Reset in the middle of a sweep
        exp_q.delete();
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(k);
        acks = 0; wr_since_ack = 0;
        @(posedge clk); #1 flush_req_i = 1'b1;
        @(posedge clk); #1 flush_req_i = 1'b0;
        n = 0; hit = 1'b0;
        while (n < 200 && !hit) begin
            @(negedge clk); #2;
            n++;
            if (vld_we_o && vld_addr_o == IW'(20)) hit = 1'b1;
        end
        chk("reached_addr20", hit, 1);
        rstn_i = 1'b0;
        #1;
        chk("async_rst_block", block_req_o, 0);
        chk("async_rst_we", vld_we_o, 0);
        chk("async_rst_addr", vld_addr_o, 0);
        chk("async_rst_busy", flush_busy_o, 0);
        chk("async_rst_ack", flush_ack_o, 0);
        exp_q.delete();
        wr_since_ack = 0; prev_ack = 1'b0; acks = 0;
        repeat (2) @(posedge clk);
        #3 rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            chk("after_rst_idle", flush_busy_o, 0);
        end
        chk("after_rst_no_ack", acks, 0);
        run_vec(5, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
